// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer bank: channel modes, default period
// and the channel-select width helper.
package tick_timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // One second at a 100 MHz system clock.
    localparam int DEFAULT_PERIOD_C = 100_000_000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_timer_bank_if.sv
// Configuration write port of the tick timer bank: one strobe selects a
// channel and loads its period and mode.
interface tick_timer_bank_if #(
    parameter int CH_W   = 2,
    parameter int TICK_W = 32
) ();

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [TICK_W-1:0] cfg_period;
    logic              cfg_mode;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_period,
        output cfg_mode
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_period,
        input cfg_mode
    );

endinterface

// File: rtl/tick_timer_channel.sv
// One programmable tick generator: divides CLK by a loadable period and emits
// a registered tick pulse, a toggling flipper and a wrapping event counter.
module tick_timer_channel
    import tick_timer_pkg::*;
#(
    parameter int TICK_W         = 32,
    parameter int COUNT_W        = 8,
    parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_C
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               load,
    input  logic [TICK_W-1:0]  period,
    input  logic               mode,
    input  logic               en,
    input  logic               clear,
    output logic               tick,
    output logic               flipper,
    output logic [COUNT_W-1:0] counter,
    output logic               busy
);

    logic [TICK_W-1:0]  period_q, period_d;
    mode_e              mode_q, mode_d;
    logic               armed_q, armed_d;
    logic [TICK_W-1:0]  ticks_q, ticks_d;
    logic [COUNT_W-1:0] counter_q, counter_d;
    logic               flipper_q, flipper_d;
    logic               tick_q, tick_d;

    logic run;
    logic terminal;

    assign busy     = (period_q != '0) && ((mode_q == MODE_PERIODIC) || armed_q);
    assign run      = en && busy;
    assign terminal = run && (ticks_q == period_q - TICK_W'(1));

    always_comb begin
        period_d  = period_q;
        mode_d    = mode_q;
        armed_d   = armed_q;
        ticks_d   = ticks_q;
        counter_d = counter_q;
        flipper_d = flipper_q;
        tick_d    = 1'b0;

        if (load) begin
            period_d = period;
            mode_d   = mode_e'(mode);
            armed_d  = mode;
            ticks_d  = '0;
        end else if (terminal) begin
            ticks_d   = '0;
            tick_d    = 1'b1;
            counter_d = counter_q + COUNT_W'(1);
            flipper_d = ~flipper_q;
            if (mode_q == MODE_ONESHOT) begin
                armed_d = 1'b0;
            end
        end else if (run) begin
            ticks_d = ticks_q + TICK_W'(1);
        end

        // Clear wins over a terminal event, so a one-shot stays armed.
        if (clear) begin
            ticks_d   = '0;
            counter_d = '0;
            flipper_d = 1'b0;
            tick_d    = 1'b0;
            armed_d   = load ? mode : armed_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            period_q  <= TICK_W'(DEFAULT_PERIOD);
            mode_q    <= MODE_PERIODIC;
            armed_q   <= 1'b0;
            ticks_q   <= '0;
            counter_q <= '0;
            flipper_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            period_q  <= period_d;
            mode_q    <= mode_d;
            armed_q   <= armed_d;
            ticks_q   <= ticks_d;
            counter_q <= counter_d;
            flipper_q <= flipper_d;
            tick_q    <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign flipper = flipper_q;
    assign counter = counter_q;

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of independent tick generators sharing one configuration write port;
// feeds display refresh, LED blink and scheduler timeouts.
module tick_timer_bank
    import tick_timer_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int TICK_W         = 32,
    parameter int COUNT_W        = 8,
    parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_C
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    tick_timer_bank_if.slave            cfg,
    input  logic [CHANNELS-1:0]         en,
    input  logic [CHANNELS-1:0]         clear,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         flipper,
    output logic [CHANNELS*COUNT_W-1:0] counter,
    output logic [CHANNELS-1:0]         busy
);

    localparam int CH_W = ch_width(CHANNELS);

    // Out-of-range channel numbers match no decoder and are dropped.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic load;

        assign load = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));

        tick_timer_channel #(
            .TICK_W         (TICK_W),
            .COUNT_W        (COUNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .load    (load),
            .period  (cfg.cfg_period),
            .mode    (cfg.cfg_mode),
            .en      (en[gi]),
            .clear   (clear[gi]),
            .tick    (tick[gi]),
            .flipper (flipper[gi]),
            .counter (counter[gi*COUNT_W +: COUNT_W]),
            .busy    (busy[gi])
        );
    end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench for tick_timer_bank: three channels, default period of ten
// cycles, one line printed per configuration write.
module tb_tick_timer_bank;

    localparam int CHANNELS = 3;
    localparam int TICK_W   = 32;
    localparam int COUNT_W  = 8;
    localparam int DEF_P    = 10;
    localparam int CH_W     = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [CHANNELS-1:0]         en;
    logic [CHANNELS-1:0]         clear;
    logic [CHANNELS-1:0]         tick;
    logic [CHANNELS-1:0]         flipper;
    logic [CHANNELS*COUNT_W-1:0] counter;
    logic [CHANNELS-1:0]         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int nt;

    tick_timer_bank_if #(.CH_W(CH_W), .TICK_W(TICK_W)) cfg_if ();

    tick_timer_bank #(
        .CHANNELS       (CHANNELS),
        .TICK_W         (TICK_W),
        .COUNT_W        (COUNT_W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .cfg     (cfg_if),
        .en      (en),
        .clear   (clear),
        .tick    (tick),
        .flipper (flipper),
        .counter (counter),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int p, input logic m);
        cfg_if.cfg_ch     = CH_W'(ch);
        cfg_if.cfg_period = TICK_W'(p);
        cfg_if.cfg_mode   = m;
        cfg_if.cfg_we     = 1'b1;
        step();
        cfg_if.cfg_we     = 1'b0;
        $display("cfg write ch=%0d period=%0d mode=%0d", ch, p, m);
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return counter[ch*COUNT_W +: COUNT_W];
    endfunction

    initial begin
        rst_n             = 1'b0;
        en                = '0;
        clear             = '0;
        cfg_if.cfg_we     = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_mode   = 1'b0;
        step();
        step();
        chk("reset_tick", 32'(tick), 0);
        chk("reset_flipper", 32'(flipper), 0);
        chk("reset_counter", 32'(counter), 0);
        chk("reset_busy", 32'(busy), 32'h7);
        rst_n = 1'b1;

        // ch0 periodic P=3
        en[0] = 1'b1;
        write(0, 3, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("p3_tick", 32'(tick[0]), 32'((k % 3) == 0));
            chk("p3_counter", 32'(cnt(0)), k / 3);
            chk("p3_flipper", 32'(flipper[0]), (k / 3) % 2);
        end

        // ch1 P=1 for 256 cycles: counter wraps
        en[1] = 1'b1;
        write(1, 1, 1'b0);
        for (int k = 1; k <= 256; k++) begin
            step();
            chk("p1_tick", 32'(tick[1]), 1);
            if (k == 255) chk("p1_counter_255", 32'(cnt(1)), 255);
        end
        chk("p1_counter_wrap", 32'(cnt(1)), 0);
        chk("p1_flipper", 32'(flipper[1]), 0);
        en[1] = 1'b0;

        // ch2 one-shot P=5
        en[2] = 1'b1;
        write(2, 5, 1'b1);
        chk("os_armed_busy", 32'(busy[2]), 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("os_tick", 32'(tick[2]), 32'(k == 5));
            chk("os_busy", 32'(busy[2]), 32'(k != 5));
        end
        chk("os_counter", 32'(cnt(2)), 1);
        nt = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            nt += int'(tick[2]);
        end
        chk("os_no_more_ticks", nt, 0);
        write(2, 5, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("os_rearm_tick", 32'(tick[2]), 32'(k == 5));
        end
        chk("os_rearm_counter", 32'(cnt(2)), 2);
        nt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            nt += int'(tick[2]);
        end
        chk("os_rearm_single", nt, 0);

        // ch0 P=4 with simultaneous clear, pause of 3 cycles, clear on terminal
        clear[0] = 1'b1;
        write(0, 4, 1'b0);
        clear[0] = 1'b0;
        chk("clr_load_counter", 32'(cnt(0)), 0);
        chk("clr_load_flipper", 32'(flipper[0]), 0);
        for (int k = 1; k <= 15; k++) begin
            if (k == 3)  en[0] = 1'b0;
            if (k == 6)  en[0] = 1'b1;
            if (k == 11) clear[0] = 1'b1;
            if (k == 12) clear[0] = 1'b0;
            step();
            chk("pause_tick", 32'(tick[0]), 32'((k == 7) || (k == 15)));
            chk("pause_counter", 32'(cnt(0)), 32'(((k >= 7) && (k <= 10)) || (k == 15)));
            chk("pause_flipper", 32'(flipper[0]), 32'(((k >= 7) && (k <= 10)) || (k == 15)));
        end

        // one-cycle reset mid-count on all channels
        en = 3'b111;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_tick", 32'(tick), 0);
        chk("midrst_counter", 32'(counter), 0);
        chk("midrst_flipper", 32'(flipper), 0);
        chk("midrst_busy", 32'(busy), 32'h7);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("midrst_first_tick", 32'(tick), (k == 10) ? 32'h7 : 32'h0);
        end
        chk("midrst_counter_1", 32'(counter), 32'h010101);

        // out-of-range channel write leaves every channel untouched
        write(3, 2, 1'b1);
        chk("oor_busy", 32'(busy), 32'h7);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("oor_tick", 32'(tick), (k == 9) ? 32'h7 : 32'h0);
        end
        chk("oor_counter", 32'(counter), 32'h020202);

        // P=0 halts a channel
        write(1, 0, 1'b0);
        chk("p0_busy", 32'(busy), 32'h5);
        nt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            nt += int'(tick[1]);
        end
        chk("p0_no_ticks", nt, 0);
        chk("p0_counter_hold", 32'(cnt(1)), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_timer_bank.md
# tick_timer_bank

Parametrised bank of independent programmable tick generators for the iCEstick minimal-OS design. Each channel divides `CLK` by a runtime-loadable period and produces a one-cycle `tick` pulse, a toggling `flipper` and a wrapping event `counter`. Each channel runs periodic or one-shot. The bank replaces the single fixed-period per-second counter, feeding display refresh, LED blink and OS scheduler timeouts from one block.

## Interface
- `CHANNELS`, 4: number of independent channels (≥1).
- `TICK_W`, 32: width of the period and internal tick counter.
- `COUNT_W`, 8: width of each channel's event counter.
- `DEFAULT_PERIOD`, 100000000: period loaded at reset, which is 1 s at 100 MHz.
- `CH_W`, derived: max(1, clog2(CHANNELS)).

Ports:
- `CLK` in 1: single clock; all logic on its rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in CH_W: target channel; writes with `cfg_ch` ≥ CHANNELS are ignored.
- `cfg_period` in TICK_W: new period P in cycles; P = 0 halts the channel.
- `cfg_mode` in 1: 0 = periodic, 1 = one-shot (a write with mode 1 arms the channel).
- `en` in CHANNELS: per-channel run enable; when low, the channel pauses.
- `clear` in CHANNELS: per-channel clear of the count state.
- `tick` out CHANNELS: one-cycle terminal pulse (registered).
- `flipper` out CHANNELS: toggles on every tick.
- `counter` out CHANNELS*COUNT_W: channel i occupies bits `[i*COUNT_W +: COUNT_W]`.
- `busy` out CHANNELS: the channel will produce ticks if `en` is high.

## Operation
- **Per-channel state:** `period`, `mode`, `armed`, `ticks` (TICK_W), `counter`, `flipper`, `tick`.
- **Counting condition:** `en[i]` && period ≠ 0 && (mode = periodic || `armed`). Call this "run".
- **Terminal count:** on a run cycle with `ticks` = P−1, the channel does all of the following at once:
  - `ticks` ← 0
  - `tick` ← 1
  - `counter` ← `counter`+1, wrapping modulo 2^COUNT_W
  - `flipper` toggles
  - in one-shot mode, `armed` ← 0
- **Other run cycles:** `ticks` ← `ticks`+1 and `tick` ← 0.
- **Not running:** `ticks` holds and `tick` ← 0. A pause therefore resumes the count where it stopped.
- **Config write** to channel i:
  - `period` and `mode` are loaded and `ticks` ← 0.
  - `armed` ← `cfg_mode`.
  - `counter` and `flipper` are preserved.
  - Any terminal event in the same cycle is suppressed (`tick` ← 0).
- **`clear[i]`:** `ticks`, `counter`, `flipper` and `tick` ← 0. `period`, `mode` and `armed` are unchanged.
- **Priority, highest first:** `RST_N` low, then `clear`, then config write, then terminal, then increment.
- **Simultaneous clear and config write** on the same channel: both apply (new period/mode loaded, count state zeroed).
- **`busy[i]`:** period ≠ 0 && (mode = periodic || `armed`), combinational from registers.
- **Reset values** (every channel):
  - `period` = DEFAULT_PERIOD, `mode` = periodic, `armed` = 0
  - `ticks` = 0, `counter` = 0, `flipper` = 0, `tick` = 0
  - hence `busy` = 1 after reset.
- **Reset mid-count:** aborts the count immediately; no tick is emitted on the reset cycle.

## Timing
- P is loaded at edge E with `en` held high. The first `tick` goes high after edge E+P and lasts exactly one cycle. Subsequent ticks follow every P cycles; there is no extra dead cycle.
- P = 1: `tick` stays high continuously and `counter` increments every cycle.
- `counter` and `flipper` update on the same edge that raises `tick`.
- Deasserting `en` for k cycles delays the next tick by exactly k cycles.
- One-shot: exactly one tick, P cycles after arming. `busy` falls on the same edge as the tick.
- Channels are fully independent; there is no cross-channel coupling.

## Structure
- **Shared package `tick_timer_pkg`:** mode constants `MODE_PERIODIC` = 0 and `MODE_ONESHOT` = 1, plus the default period constant.
- **Sub-module `tick_timer_channel`:** one channel's registers and next-state logic, with inputs `CLK`, `RST_N`, `load`, `period`, `mode`, `en`, `clear`.
- **Top level:** decodes `cfg_we`/`cfg_ch` into per-channel `load` and instantiates CHANNELS channels in a generate loop.

## Test plan
- Write ch0 P=3 periodic, `en`=1 → `tick[0]` high 3, 6 and 9 cycles after the write; `counter[0]` = 1, 2, 3; `flipper[0]` = 1, 0, 1.
- COUNT_W=8, ch1 P=1 run 256 cycles → `counter[1]` goes 255→0, `tick[1]` constantly high, `flipper[1]` = 0 at the end.
- Write ch2 P=5 one-shot → single tick 5 cycles after the write, `busy[2]` falls with it, no further ticks over 50 cycles; rewriting with mode 1 produces exactly one more tick.
- ch0 P=4, drop `en` for 3 cycles mid-count → tick delayed by exactly 3 cycles; `clear` asserted on a terminal cycle → no tick, `counter` = 0.
- Pull `RST_N` low for one cycle mid-count on all channels → all outputs 0 the next cycle; the first tick comes DEFAULT_PERIOD cycles later (run with DEFAULT_PERIOD=10).
- Write with `cfg_ch` = CHANNELS (CHANNELS=3) → no channel state changes; P=0 write → `busy` = 0, no ticks.
